// File: rtl/iso_rx_sequencer.sv
// Receive-side sequencer for an ISO 7816 style character link: sequences byte
// acceptance, T=0 error signalling with retries, character waiting time and a 2-entry output FIFO.
module iso_rx_sequencer #(
  parameter int CLOCK_PER_BIT_WIDTH = 13,
  parameter int CWT_WIDTH           = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic [CWT_WIDTH-1:0]           cwtEtus,
  input  logic                           errSigEnable,
  input  logic [1:0]                     errSigEtus,
  input  logic [2:0]                     maxRetries,
  input  logic                           clearFlags,
  input  logic [7:0]                     rxData,
  input  logic                           rxDataReady,
  input  logic                           rxFrameError,
  input  logic                           rxOverrun,
  input  logic                           rxRun,
  output logic                           rxAckFlags,
  output logic                           errSig,
  output logic [7:0]                     outData,
  output logic                           outValid,
  input  logic                           outReady,
  output logic                           overrunFlag,
  output logic                           parityFlag,
  output logic                           retryExceededFlag,
  output logic                           timeoutFlag,
  output logic                           busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    ERRSIG,
    TIMEOUT
  } seqState;

  localparam logic [CLOCK_PER_BIT_WIDTH-1:0] CLK_ONE = 1;
  localparam logic [CWT_WIDTH:0]             ETU_ONE = 1;

  seqState state;
  seqState nextState;

  logic [CLOCK_PER_BIT_WIDTH-1:0] clkCnt;
  logic [CWT_WIDTH-1:0]           etuCnt;
  logic [2:0]                     retryCnt;
  logic                           firstCycle;

  logic                 etuTick;
  logic [CWT_WIDTH:0]   etuNext;
  logic [1:0]           errSigLen;
  logic                 counting;

  logic pushReq;
  logic retryInc;
  logic retryClr;
  logic setParity;
  logic setRetryExc;
  logic setTimeout;

  logic [7:0] fifoMem [2];
  logic       wrPtr;
  logic       rdPtr;
  logic [1:0] fifoCount;
  logic       fifoFull;
  logic       fifoPop;
  logic       fifoPush;
  logic       pushDrop;
  logic       setOverrun;

  assign counting  = (state == WAIT) || (state == ERRSIG);
  // Compare with >= so a clocksPerBit lowered mid-ETU cannot let clkCnt run past it.
  assign etuTick   = counting && (clkCnt >= clocksPerBit);
  assign etuNext   = {1'b0, etuCnt} + ETU_ONE;
  assign errSigLen = (errSigEtus == 2'd0) ? 2'd1 : errSigEtus;

  // NOTE: every output of this block gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    nextState   = state;
    pushReq     = 1'b0;
    retryInc    = 1'b0;
    retryClr    = 1'b0;
    setParity   = 1'b0;
    setRetryExc = 1'b0;
    setTimeout  = 1'b0;
    if (!enable) begin
      nextState = IDLE;
    end else begin
      unique case (state)
        IDLE: nextState = WAIT;
        WAIT: begin
          if (rxFrameError) begin
            if (!errSigEnable) begin
              setParity = 1'b1;
              nextState = ACK;
            end else if (retryCnt < maxRetries) begin
              retryInc  = 1'b1;
              nextState = ERRSIG;
            end else begin
              setRetryExc = 1'b1;
              setParity   = 1'b1;
              retryClr    = 1'b1;
              nextState   = ACK;
            end
          end else if (rxDataReady) begin
            pushReq   = 1'b1;
            retryClr  = 1'b1;
            nextState = ACK;
          end else if (!rxRun && (cwtEtus != '0) && etuTick &&
                       (etuNext >= {1'b0, cwtEtus})) begin
            setTimeout = 1'b1;
            nextState  = TIMEOUT;
          end
        end
        ACK: nextState = WAIT;
        ERRSIG: begin
          if (etuTick && (etuNext >= {{(CWT_WIDTH-1){1'b0}}, errSigLen}))
            nextState = WAIT;
        end
        TIMEOUT: nextState = TIMEOUT;
        default: nextState = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      firstCycle <= 1'b0;
    end else begin
      state      <= nextState;
      firstCycle <= (nextState != state);
    end
  end

  // ETU timing restarts on every state change and is frozen while a character is being received.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkCnt <= '0;
      etuCnt <= '0;
    end else if ((nextState != state) || !counting || ((state == WAIT) && rxRun)) begin
      clkCnt <= '0;
      etuCnt <= '0;
    end else if (etuTick) begin
      clkCnt <= '0;
      if (etuCnt != '1) etuCnt <= etuCnt + ETU_ONE[CWT_WIDTH-1:0];
    end else begin
      clkCnt <= clkCnt + CLK_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retryCnt <= '0;
    end else if ((nextState == IDLE) || retryClr) begin
      retryCnt <= '0;
    end else if (retryInc && (retryCnt != 3'd7)) begin
      retryCnt <= retryCnt + 3'd1;
    end
  end

  assign fifoFull = (fifoCount == 2'd2);
  assign outValid = (fifoCount != 2'd0);
  assign fifoPop  = outValid && outReady;
  assign fifoPush = pushReq && (!fifoFull || fifoPop);
  assign pushDrop = pushReq && fifoFull && !fifoPop;
  assign outData  = fifoMem[rdPtr];

  // NOTE: the two storage entries are reset because outData is read straight from
  // them and must show 0x00 out of reset; larger buffers would be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
      wrPtr      <= 1'b0;
      rdPtr      <= 1'b0;
      fifoCount  <= '0;
    end else begin
      if (fifoPush) begin
        fifoMem[wrPtr] <= rxData;
        wrPtr          <= ~wrPtr;
      end
      if (fifoPop) rdPtr <= ~rdPtr;
      unique case ({fifoPush, fifoPop})
        2'b10:   fifoCount <= fifoCount + 2'd1;
        2'b01:   fifoCount <= fifoCount - 2'd1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  assign setOverrun = pushDrop || (rxOverrun && (state != IDLE));

  // A set event in the same cycle as clearFlags takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrunFlag       <= 1'b0;
      parityFlag        <= 1'b0;
      retryExceededFlag <= 1'b0;
      timeoutFlag       <= 1'b0;
    end else begin
      if (setOverrun)       overrunFlag <= 1'b1;
      else if (clearFlags)  overrunFlag <= 1'b0;
      if (setParity)        parityFlag <= 1'b1;
      else if (clearFlags)  parityFlag <= 1'b0;
      if (setRetryExc)      retryExceededFlag <= 1'b1;
      else if (clearFlags)  retryExceededFlag <= 1'b0;
      if (setTimeout)       timeoutFlag <= 1'b1;
      else if (clearFlags)  timeoutFlag <= 1'b0;
    end
  end

  assign errSig     = (state == ERRSIG);
  assign rxAckFlags = (state == ACK) || ((state == ERRSIG) && firstCycle);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_iso_rx_sequencer.sv
// Directed bench for iso_rx_sequencer: output bytes are checked against a queue
// of expected values filled as stimulus bytes are offered.
module tb_iso_rx_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [12:0] clocksPerBit;
  logic [15:0] cwtEtus;
  logic        errSigEnable;
  logic [1:0]  errSigEtus;
  logic [2:0]  maxRetries;
  logic        clearFlags;
  logic [7:0]  rxData;
  logic        rxDataReady;
  logic        rxFrameError;
  logic        rxOverrun;
  logic        rxRun;
  logic        rxAckFlags;
  logic        errSig;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady;
  logic        overrunFlag;
  logic        parityFlag;
  logic        retryExceededFlag;
  logic        timeoutFlag;
  logic        busy;

  int passCnt  = 0;
  int checkCnt = 0;
  int failCnt  = 0;
  logic [7:0] sbQ [$];

  iso_rx_sequencer #(.CLOCK_PER_BIT_WIDTH(13), .CWT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clocksPerBit(clocksPerBit),
    .cwtEtus(cwtEtus), .errSigEnable(errSigEnable), .errSigEtus(errSigEtus),
    .maxRetries(maxRetries), .clearFlags(clearFlags), .rxData(rxData),
    .rxDataReady(rxDataReady), .rxFrameError(rxFrameError), .rxOverrun(rxOverrun),
    .rxRun(rxRun), .rxAckFlags(rxAckFlags), .errSig(errSig), .outData(outData),
    .outValid(outValid), .outReady(outReady), .overrunFlag(overrunFlag),
    .parityFlag(parityFlag), .retryExceededFlag(retryExceededFlag),
    .timeoutFlag(timeoutFlag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    assert (got === exp) begin
      passCnt++;
    end else begin
      failCnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs are driven and outputs sampled here.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rxData      = b;
    rxDataReady = 1'b1;
    if (sbQ.size() < 2) sbQ.push_back(b);
    cycle();
    rxDataReady = 1'b0;
    check("ack_on_byte", rxAckFlags, 1);
    cycle();
    check("ack_one_cycle", rxAckFlags, 0);
  endtask

  task automatic drainOne(input string tag);
    logic [7:0] exp;
    int n;
    n = 0;
    while (!outValid && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_valid"}, outValid, 1);
    if (sbQ.size() > 0) exp = sbQ.pop_front();
    else exp = 8'hxx;
    check({tag, "_data"}, outData, exp);
    outReady = 1'b1;
    cycle();
    outReady = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1; enable = 1'b0; clocksPerBit = 13'd3; cwtEtus = 16'd0;
    errSigEnable = 1'b0; errSigEtus = 2'd0; maxRetries = 3'd0; clearFlags = 1'b0;
    rxData = 8'h00; rxDataReady = 1'b0; rxFrameError = 1'b0; rxOverrun = 1'b0;
    rxRun = 1'b0; outReady = 1'b0;
    cycle();
    cycle();

    check("rst_busy", busy, 0);
    check("rst_valid", outValid, 0);
    check("rst_data", outData, 8'h00);
    check("rst_errsig", errSig, 0);
    check("rst_ack", rxAckFlags, 0);
    check("rst_flags", {overrunFlag, parityFlag, retryExceededFlag, timeoutFlag}, 4'b0000);

    reset  = 1'b0;
    enable = 1'b1;
    cycle();
    check("enter_wait_busy", busy, 1);

    // Single byte reaches the output with a one-cycle acknowledge.
    sendByte(8'h3B);
    check("byte_valid", outValid, 1);
    drainOne("byte_3b");
    check("empty_after_3b", outValid, 0);

    // Three bytes with the sink stalled: third is dropped and flagged.
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    check("overrun_flag", overrunFlag, 1);
    repeat (3) cycle();
    check("stall_data_stable", outData, 8'h11);
    drainOne("fifo_first");
    drainOne("fifo_second");
    check("fifo_empty", outValid, 0);

    // Push and pop on a full FIFO in the same cycle both take effect.
    clearFlags = 1'b1;
    cycle();
    clearFlags = 1'b0;
    check("clear_overrun", overrunFlag, 0);
    sendByte(8'hA1);
    sendByte(8'hA2);
    check("full_head", outData, sbQ[0]);
    void'(sbQ.pop_front());
    sbQ.push_back(8'hA3);
    rxData = 8'hA3; rxDataReady = 1'b1; outReady = 1'b1;
    cycle();
    rxDataReady = 1'b0; outReady = 1'b0;
    cycle();
    check("full_pushpop_no_overrun", overrunFlag, 0);
    drainOne("pushpop_a2");
    drainOne("pushpop_a3");

    // Error signalling: first error gets an 8-clock errSig, second exceeds retries.
    errSigEnable = 1'b1; errSigEtus = 2'd2; maxRetries = 3'd1; clocksPerBit = 13'd3;
    rxFrameError = 1'b1;
    cycle();
    rxFrameError = 1'b0;
    check("errsig_first_ack", rxAckFlags, 1);
    cnt = 0;
    while (errSig && cnt < 100) begin
      cnt++;
      cycle();
      if (cnt == 1) check("errsig_ack_once", rxAckFlags, 0);
    end
    check("errsig_length", cnt, 8);
    check("errsig_no_parity_yet", parityFlag, 0);
    rxFrameError = 1'b1;
    cycle();
    rxFrameError = 1'b0;
    check("retry_exc_no_errsig", errSig, 0);
    check("retry_exc_ack", rxAckFlags, 1);
    cycle();
    check("retry_exc_flag", retryExceededFlag, 1);
    check("retry_exc_parity", parityFlag, 1);

    // clearFlags coincident with an overrun report: the set wins.
    clearFlags = 1'b1; rxOverrun = 1'b1;
    cycle();
    clearFlags = 1'b0; rxOverrun = 1'b0;
    check("clear_vs_set_overrun", overrunFlag, 1);
    check("clear_parity", parityFlag, 0);
    check("clear_retry_exc", retryExceededFlag, 0);

    // Going idle keeps buffered data.
    sendByte(8'h5A);
    enable = 1'b0;
    cycle();
    check("idle_busy", busy, 0);
    check("idle_keeps_fifo", outValid, 1);
    drainOne("idle_drain");

    // Character waiting time: rxRun holds the count, then 5 ETUs of 10 clocks.
    errSigEnable = 1'b0; cwtEtus = 16'd5; clocksPerBit = 13'd9; rxRun = 1'b1;
    enable = 1'b1;
    cycle();
    repeat (40) cycle();
    check("rxrun_holds_cwt", timeoutFlag, 0);
    rxRun = 1'b0;
    cnt = 0;
    while (!timeoutFlag && cnt < 200) begin
      cycle();
      cnt++;
    end
    check("timeout_latency", cnt, 50);
    repeat (5) cycle();
    check("timeout_busy", busy, 1);
    enable = 1'b0;
    cycle();
    check("timeout_to_idle", busy, 0);

    // Asynchronous reset in the middle of an error signal.
    cwtEtus = 16'd0; errSigEnable = 1'b1; maxRetries = 3'd3; clocksPerBit = 13'd3;
    enable = 1'b1;
    cycle();
    sendByte(8'h77);
    rxOverrun = 1'b1;
    cycle();
    rxOverrun = 1'b0;
    rxFrameError = 1'b1;
    cycle();
    rxFrameError = 1'b0;
    cycle();
    cycle();
    check("pre_reset_errsig", errSig, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_errsig", errSig, 0);
    check("async_rst_flags", {overrunFlag, parityFlag, retryExceededFlag, timeoutFlag}, 4'b0000);
    check("async_rst_valid", outValid, 0);
    check("async_rst_data", outData, 8'h00);
    check("async_rst_busy", busy, 0);
    check("async_rst_ack", rxAckFlags, 0);
    sbQ.delete();
    cycle();
    reset = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/iso_rx_sequencer.md
ISO_RX_SEQUENCER -- requirements
Module: iso_rx_sequencer

Interface
REQ-001 SHALL have parameter CLOCK_PER_BIT_WIDTH, default 13: width of the ETU length input.
REQ-002 SHALL have parameter CWT_WIDTH, default 16: width of the waiting-time input, in ETUs.
REQ-003 SHALL have port clk  in  1  single clock; all logic in this domain.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  run the sequencer; 0 forces IDLE.
REQ-006 SHALL have port clocksPerBit  in  CLOCK_PER_BIT_WIDTH  clocks per ETU, minus 1.
REQ-007 SHALL have port cwtEtus  in  CWT_WIDTH  character waiting time in ETUs; 0 disables timeout.
REQ-008 SHALL have port errSigEnable  in  1  1 = signal parity errors (T=0 style).
REQ-009 SHALL have port errSigEtus  in  2  error-signal length in ETUs; 0 is treated as 1.
REQ-010 SHALL have port maxRetries  in  3  consecutive error signals allowed per character.
REQ-011 SHALL have port clearFlags  in  1  one-cycle clear of all sticky flags.
REQ-012 SHALL have ports rxData (in, 8), rxDataReady, rxFrameError, rxOverrun, rxRun (in, 1 each): receiver core status.
REQ-013 SHALL have port rxAckFlags  out  1  one-cycle acknowledge to the receiver core.
REQ-014 SHALL have port errSig  out  1  1 = drive the I/O line low.
REQ-015 SHALL have ports outData (out, 8), outValid (out, 1), outReady (in, 1): byte stream, valid/ready.
REQ-016 SHALL have ports overrunFlag, parityFlag, retryExceededFlag, timeoutFlag  out  1 each: sticky status.
REQ-017 SHALL have port busy  out  1  state != IDLE.

Function
REQ-018 SHALL implement the states IDLE, WAIT, ACK, ERRSIG and TIMEOUT.
REQ-019 SHALL go IDLE->WAIT when enable=1, and go to IDLE from any state one cycle after enable=0; entering IDLE clears the ETU counter, the retry counter and errSig, but SHALL NOT clear the FIFO.
REQ-020 SHALL generate an ETU tick every clocksPerBit+1 clks while in WAIT or ERRSIG; the ETU counter restarts on every state entry.
REQ-021 In WAIT, rxRun=1 SHALL hold the waiting-time counters at 0.
REQ-022 In WAIT, when rxRun=0 and cwtEtus!=0 and the elapsed ETU count reaches cwtEtus: set timeoutFlag and go to TIMEOUT; TIMEOUT SHALL remain until enable=0.
REQ-023 In WAIT, on rxDataReady=1 with rxFrameError=0: push rxData into the 2-entry FIFO, or set overrunFlag and drop the byte if the FIFO is full; reset the retry count; go to ACK.
REQ-024 In WAIT, on rxFrameError=1 with errSigEnable=0: set parityFlag, drop the byte, go to ACK.
REQ-025 In WAIT, on rxFrameError=1 with errSigEnable=1: if retry count < maxRetries, increment it and go to ERRSIG; otherwise set retryExceededFlag and parityFlag, reset the retry count, drop the byte and go to ACK.
REQ-026 rxOverrun=1 in any non-IDLE state SHALL set overrunFlag.
REQ-027 rxAckFlags SHALL be 1 for exactly the single cycle spent in ACK, and on the first cycle of ERRSIG; ACK SHALL always return to WAIT.
REQ-028 In ERRSIG, errSig=1 from its first cycle for exactly max(errSigEtus,1)*(clocksPerBit+1) clks, then errSig=0 and go to WAIT.
REQ-029 The FIFO SHALL present data first-in first-out on outData.
REQ-030 outValid=1 iff the FIFO is not empty; a pop SHALL occur on outValid&outReady.
REQ-031 A push and a pop in the same cycle SHALL both take effect, also when the FIFO is full.
REQ-032 outData SHALL remain stable while outValid=1 and outReady=0.
REQ-033 clearFlags=1 SHALL clear all four sticky flags; a set event in the same cycle SHALL win.
REQ-034 All counters SHALL saturate, never wrap.

Reset
REQ-035 reset=1 SHALL immediately force state IDLE, empty FIFO, counters 0, and rxAckFlags=errSig=outValid=busy=0, all flags=0 and outData=0x00, including mid-ERRSIG.

Verification
REQ-036 enable=1, clocksPerBit=3, byte 0x3B arrives with rxDataReady -> rxAckFlags 1 cycle, outValid=1, outData=0x3B.
REQ-037 Three bytes 0x11,0x22,0x33 arrive with outReady=0 -> the first two are held, overrunFlag=1; after outReady=1 they come out as 0x11 then 0x22.
REQ-038 errSigEnable=1, errSigEtus=2, clocksPerBit=3, maxRetries=1, two frame errors -> first gives errSig high for 8 clks; second gives no errSig, retryExceededFlag=1 and parityFlag=1.
REQ-039 cwtEtus=5, clocksPerBit=9, rxRun=0 -> timeoutFlag set 50 clks after WAIT entry, busy stays 1; enable=0 -> IDLE.
REQ-040 reset pulse mid-ERRSIG -> errSig=0 asynchronously and all flags=0; clearFlags coincident with an rxOverrun set leaves overrunFlag=1.
